// File: rtl/alu_issue_ctrl.sv
//============================================================================
// Module   : alu_issue_ctrl
// Brief    : Registered operand issue into a combinational ALU with a settle
//            window and a 2-entry result FIFO behind a valid/ready consumer.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  NOP_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    output logic [3:0]  alu_r1,
    output logic [3:0]  alu_r2,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [3:0]  res_op,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
            $error("alu_issue_ctrl: SETTLE must be within 1..15");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_can_accept;
    logic        w_accept;
    logic        w_capture;
    logic        w_pop;

    logic [3:0]  r_alu_r1;
    logic [3:0]  r_alu_r2;
    logic [3:0]  r_alu_op;
    logic [7:0]  r_buf_data [2];
    logic [3:0]  r_buf_op   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // in_ready is derived from registered state only, never from in_valid.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_can_accept = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                w_can_accept = (r_count != 2'd2);
                if (in_valid && w_can_accept) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = C_SETTLE_LOAD;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_pop = (r_count != 2'd0) && res_ready;

    // On a simultaneous push and pop with a full buffer the write slot equals
    // the head being retired, so ordering is still preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_r1      <= 4'd0;
            r_alu_r2      <= 4'd0;
            r_alu_op      <= NOP_OP;
            r_buf_data[0] <= 8'd0;
            r_buf_data[1] <= 8'd0;
            r_buf_op[0]   <= 4'd0;
            r_buf_op[1]   <= 4'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_op_count    <= 16'd0;
        end else begin
            if (w_accept) begin
                r_alu_r1 <= in_a;
                r_alu_r2 <= in_b;
                r_alu_op <= in_op;
            end else if (w_capture) begin
                r_alu_op <= NOP_OP;
            end
            if (w_capture) begin
                r_buf_data[r_wr_ptr] <= alu_out;
                r_buf_op[r_wr_ptr]   <= r_alu_op;
                r_wr_ptr             <= ~r_wr_ptr;
                r_op_count           <= r_op_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_can_accept;
    assign alu_r1    = r_alu_r1;
    assign alu_r2    = r_alu_r2;
    assign alu_op    = r_alu_op;
    assign res_valid = (r_count != 2'd0);
    assign res_data  = r_buf_data[r_rd_ptr];
    assign res_op    = r_buf_op[r_rd_ptr];
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Scoreboard bench for alu_issue_ctrl with SETTLE=1 and SETTLE=3.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;

    logic        in_valid1, in_ready1, res_valid1, res_ready1, busy1;
    logic [3:0]  in_op1, in_a1, in_b1, alu_r1_1, alu_r2_1, alu_op1, res_op1;
    logic [7:0]  alu_out1, res_data1;
    logic [15:0] op_count1;

    logic        in_valid3, in_ready3, res_valid3, res_ready3, busy3;
    logic [3:0]  in_op3, in_a3, in_b3, alu_r1_3, alu_r2_3, alu_op3, res_op3;
    logic [7:0]  alu_out3, res_data3, noise3;
    logic [15:0] op_count3;

    logic [11:0] q1 [$];
    logic [11:0] q3 [$];
    logic [11:0] exp1, exp3;
    logic [7:0]  noise_pat [3];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            4'd0:    return 8'(a) + 8'(b);
            4'd1:    return 8'(a) - 8'(b);
            4'd2:    return {4'd0, a & b};
            4'd3:    return {4'd0, a | b};
            4'd4:    return {4'd0, a ^ b};
            4'd5:    return 8'(a) * 8'(b);
            default: return {a, b};
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    alu_issue_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1), .in_a(in_a1), .in_b(in_b1),
        .alu_r1(alu_r1_1), .alu_r2(alu_r2_1), .alu_op(alu_op1), .alu_out(alu_out1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1), .res_op(res_op1),
        .busy(busy1), .op_count(op_count1)
    );

    alu_issue_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op3), .in_a(in_a3), .in_b(in_b3),
        .alu_r1(alu_r1_3), .alu_r2(alu_r2_3), .alu_op(alu_op3), .alu_out(alu_out3),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3), .res_op(res_op3),
        .busy(busy3), .op_count(op_count3)
    );

    assign alu_out1 = alu_model(alu_op1, alu_r1_1, alu_r2_1);
    assign alu_out3 = alu_model(alu_op3, alu_r1_3, alu_r2_3) ^ noise3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && res_valid1 && res_ready1) begin
            if (q1.size() == 0) check_value("sb1_unexpected", 32'(res_valid1), 32'd0);
            else begin
                exp1 = q1.pop_front();
                check_value("sb1_result", {20'd0, res_data1, res_op1}, {20'd0, exp1});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid3 && res_ready3) begin
            if (q3.size() == 0) check_value("sb3_unexpected", 32'(res_valid3), 32'd0);
            else begin
                exp3 = q3.pop_front();
                check_value("sb3_result", {20'd0, res_data3, res_op3}, {20'd0, exp3});
            end
        end
    end

    // Holds in_valid until accepted; returns one #1 after the accept edge.
    task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                          input bit track);
        int waited = 0;
        in_a1     = a;
        in_b1     = b;
        in_op1    = op;
        in_valid1 = 1'b1;
        @(negedge clk);
        while (!in_ready1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready1) begin
            check_value("issue_timeout", 32'(in_ready1), 32'd1);
            in_valid1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        if (track) q1.push_back({alu_model(op, a, b), op});
    endtask

    initial begin
        noise_pat[0] = 8'hAA;
        noise_pat[1] = 8'h55;
        noise_pat[2] = 8'h3C;
        rst = 1'b1;
        in_valid1 = 1'b0; in_a1 = 4'd0; in_b1 = 4'd0; in_op1 = 4'd0; res_ready1 = 1'b0;
        in_valid3 = 1'b0; in_a3 = 4'd0; in_b3 = 4'd0; in_op3 = 4'd0; res_ready3 = 1'b1;
        noise3 = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_alu_op", 32'(alu_op1), 32'hF);
        check_value("rst_alu_r", {24'd0, alu_r1_1, alu_r2_1}, 32'd0);
        check_value("rst_res_valid", 32'(res_valid1), 32'd0);
        check_value("rst_res_head", {20'd0, res_data1, res_op1}, 32'd0);
        check_value("rst_in_ready", 32'(in_ready1), 32'd1);
        check_value("rst_busy", 32'(busy1), 32'd0);
        check_value("rst_op_count", 32'(op_count1), 32'd0);

        // SETTLE=1 single op: 7 + 4 = 0x0B
        @(posedge clk); #1;
        issue1(4'd7, 4'd4, 4'd0, 1'b1);
        @(negedge clk);
        check_value("s1_busy", 32'(busy1), 32'd1);
        check_value("s1_in_ready_low", 32'(in_ready1), 32'd0);
        check_value("s1_operands", {20'd0, alu_r1_1, alu_r2_1, alu_op1}, 32'h740);
        @(negedge clk);
        check_value("s1_res_valid", 32'(res_valid1), 32'd1);
        check_value("s1_res_head", {20'd0, res_data1, res_op1}, 32'h0B0);
        check_value("s1_op_count", 32'(op_count1), 32'd1);
        check_value("s1_alu_nop", 32'(alu_op1), 32'hF);
        check_value("s1_idle", {30'd0, busy1, in_ready1}, 32'b01);
        @(posedge clk); #1 res_ready1 = 1'b1;
        @(posedge clk); #1;

        // SETTLE=3: ALU output disturbed during the window, only the last value counts
        in_a3 = 4'd9; in_b3 = 4'd5; in_op3 = 4'd1; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        q3.push_back({alu_model(4'd1, 4'd9, 4'd5) ^ 8'h3C, 4'd1});
        for (int k = 0; k < 3; k++) begin
            noise3 = noise_pat[k];
            @(negedge clk);
            check_value("s3_in_ready_low", 32'(in_ready3), 32'd0);
            @(posedge clk); #1;
        end
        noise3 = 8'h00;
        @(negedge clk);
        check_value("s3_in_ready_back", 32'(in_ready3), 32'd1);
        check_value("s3_res_head", {20'd0, res_data3, res_op3}, 32'h381);

        // Back-pressure: two buffered results stall the third op
        @(posedge clk); #1 res_ready1 = 1'b0;
        issue1(4'd1, 4'd0, 4'd0, 1'b1);
        issue1(4'd2, 4'd0, 4'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_value("full_in_ready", 32'(in_ready1), 32'd0);
        check_value("full_head", {20'd0, res_data1, res_op1}, 32'h010);
        in_a1 = 4'd3; in_b1 = 4'd0; in_op1 = 4'd0; in_valid1 = 1'b1;
        repeat (3) @(negedge clk);
        check_value("op3_stalled", {30'd0, busy1, in_ready1}, 32'd0);
        check_value("full_head_stable", {20'd0, res_data1, res_op1}, 32'h010);
        @(posedge clk); #1 res_ready1 = 1'b1;
        issue1(4'd3, 4'd0, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Simultaneous push and pop at count=1: head advances to the new result
        res_ready1 = 1'b0;
        issue1(4'd2, 4'd3, 4'd5, 1'b1);
        issue1(4'd4, 4'd1, 4'd3, 1'b1);
        res_ready1 = 1'b1;
        @(posedge clk); #1 res_ready1 = 1'b0;
        @(negedge clk);
        check_value("pp_head", {19'd0, res_valid1, res_data1, res_op1}, 32'h1053);
        @(posedge clk); #1 res_ready1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_value("pp_count_one", 32'(res_valid1), 32'd0);

        // Reset in the middle of an SETTLE=3 execution
        @(posedge clk); #1;
        in_a3 = 4'd3; in_b3 = 4'd3; in_op3 = 4'd0; in_valid3 = 1'b1;
        @(posedge clk); #1 in_valid3 = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_value("mid_rst_state", {28'd0, busy3, res_valid3, in_ready3, busy1}, 32'b0010);
        check_value("mid_rst_alu", {20'd0, alu_r1_3, alu_r2_3, alu_op3}, 32'h00F);
        check_value("mid_rst_head", {20'd0, res_data3, res_op3}, 32'd0);
        check_value("mid_rst_op_count", 32'(op_count3), 32'd0);
        repeat (4) @(negedge clk);
        check_value("mid_rst_no_push", {30'd0, res_valid3, busy3}, 32'd0);
        check_value("mid_rst_op_count_hold", 32'(op_count3), 32'd0);

        // op_count wraps from FFFF to 0
        @(posedge clk); #1 force dut1.r_op_count = 16'hFFFF;
        @(posedge clk); #1 release dut1.r_op_count;
        @(negedge clk);
        check_value("wrap_preset", 32'(op_count1), 32'hFFFF);
        @(posedge clk); #1;
        issue1(4'd5, 4'd6, 4'd4, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_value("wrap_op_count", 32'(op_count1), 32'd0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("sb1_drained", 32'(q1.size()), 32'd0);
        check_value("sb3_drained", 32'(q3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
